// File: rtl/risc_mc_control_if.sv
// Memory handshake between the multi-cycle control sequencer and the memory port.
// The sequencer (master) drives the request and address select; memory answers with ready.
interface risc_mc_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/risc_mc_control.sv
// Multi-cycle control sequencer for the RISC core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, one datapath phase per cycle,
// stalling on the memory handshake with a bounded wait. Also handles halt/resume,
// the illegal-opcode trap and counting of retired instructions.
module risc_mc_control #(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] instr_opcode,
    input  logic [3:0]          flags_in,
    input  logic                halt_req,
    input  logic                resume,
    risc_mc_control_if.master   mem_bus,
    output logic                ir_load,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                link_write,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                flags_write,
    output logic [2:0]          state,
    output logic                halted,
    output logic                bus_err,
    output logic [CNT_W-1:0]    instr_retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // Wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(6'h00);
    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(6'h01);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6'h02);
    localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(6'h03);
    localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6'h04);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'h05);
    localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(6'h06);
    localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(6'h07);
    localparam logic [OPCODE_W-1:0] OP_BRZ  = OPCODE_W'(6'h08);
    localparam logic [OPCODE_W-1:0] OP_BRN  = OPCODE_W'(6'h09);
    localparam logic [OPCODE_W-1:0] OP_BRC  = OPCODE_W'(6'h0A);
    localparam logic [OPCODE_W-1:0] OP_BRO  = OPCODE_W'(6'h0B);
    localparam logic [OPCODE_W-1:0] OP_BRA  = OPCODE_W'(6'h0C);
    localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(6'h0D);
    localparam logic [OPCODE_W-1:0] OP_RET  = OPCODE_W'(6'h0E);
    localparam logic [OPCODE_W-1:0] OP_HLT  = {OPCODE_W{1'b1}};

    // Conditional branches test one flag of {Z,N,C,O}; BRA is unconditional.
    function automatic logic branch_taken(input logic [OPCODE_W-1:0] op, input logic [3:0] fl);
        logic taken;
        case (op)
            OP_BRZ:  taken = fl[3];
            OP_BRN:  taken = fl[2];
            OP_BRC:  taken = fl[1];
            OP_BRO:  taken = fl[0];
            OP_BRA:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // ADDI and the memory ops all compute base + immediate.
    function automatic logic [1:0] alu_op_of(input logic [OPCODE_W-1:0] op);
        logic [1:0] code;
        case (op)
            OP_SUB:  code = 2'b01;
            OP_AND:  code = 2'b10;
            OP_OR:   code = 2'b11;
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    state_t             retire_next_s;
    logic [TO_W-1:0]    wait_cnt_r;
    logic [CNT_W-1:0]   instr_retired_r;
    logic               bus_err_r;
    logic               retire_s;
    logic               waiting_s;
    logic               wait_expired_s;
    logic               ir_load_s;
    logic               pc_write_s;
    logic [1:0]         pc_src_s;
    logic               link_write_s;
    logic               mem_req_s;
    logic               mem_we_s;
    logic               mem_addr_sel_s;
    logic               alu_src_s;
    logic [1:0]         alu_op_s;
    logic               reg_dst_s;
    logic               mem_to_reg_s;
    logic               reg_write_s;
    logic               flags_write_s;

    // Next-state, retire and phase strobes from the current state, opcode, flags and ready.
    always_comb begin
        next_state_s   = state_r;
        retire_s       = 1'b0;
        ir_load_s      = 1'b0;
        pc_write_s     = 1'b0;
        pc_src_s       = 2'b00;
        link_write_s   = 1'b0;
        mem_req_s      = 1'b0;
        mem_we_s       = 1'b0;
        mem_addr_sel_s = 1'b0;
        alu_src_s      = 1'b0;
        alu_op_s       = 2'b00;
        reg_dst_s      = 1'b0;
        mem_to_reg_s   = 1'b0;
        reg_write_s    = 1'b0;
        flags_write_s  = 1'b0;
        wait_expired_s = (wait_cnt_r == TO_W'(MEM_TIMEOUT - 1));
        // A pending halt request diverts the instruction boundary into HALT.
        retire_next_s  = halt_req ? S_HALT : S_FETCH;

        case (state_r)
            S_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_bus.mem_ready) begin
                    ir_load_s    = 1'b1;
                    pc_write_s   = 1'b1;
                    next_state_s = S_DECODE;
                end else if (wait_expired_s) begin
                    next_state_s = S_ERR;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (instr_opcode)
                    OP_NOP: begin
                        retire_s     = 1'b1;
                        next_state_s = retire_next_s;
                    end
                    OP_BRZ, OP_BRN, OP_BRC, OP_BRO, OP_BRA: begin
                        pc_write_s   = branch_taken(instr_opcode, flags_in);
                        pc_src_s     = 2'b01;
                        retire_s     = 1'b1;
                        next_state_s = retire_next_s;
                    end
                    OP_JMP: begin
                        pc_write_s   = 1'b1;
                        pc_src_s     = 2'b10;
                        link_write_s = 1'b1;
                        retire_s     = 1'b1;
                        next_state_s = retire_next_s;
                    end
                    OP_RET: begin
                        pc_write_s   = 1'b1;
                        pc_src_s     = 2'b11;
                        retire_s     = 1'b1;
                        next_state_s = retire_next_s;
                    end
                    OP_HLT:                                          next_state_s = S_HALT;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST: next_state_s = S_EXEC;
                    default:                                         next_state_s = S_ERR;
                endcase
            end
            S_EXEC: begin
                alu_src_s = (instr_opcode == OP_ADDI) || (instr_opcode == OP_LD) || (instr_opcode == OP_ST);
                alu_op_s  = alu_op_of(instr_opcode);
                case (instr_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        flags_write_s = 1'b1;
                        next_state_s  = S_WB;
                    end
                    OP_LD, OP_ST: next_state_s = S_MEM;
                    default:      next_state_s = S_ERR;
                endcase
            end
            S_MEM: begin
                mem_req_s      = 1'b1;
                mem_addr_sel_s = 1'b1;
                mem_we_s       = (instr_opcode == OP_ST);
                if (mem_bus.mem_ready) begin
                    if (instr_opcode == OP_ST) begin
                        retire_s     = 1'b1;
                        next_state_s = retire_next_s;
                    end else begin
                        next_state_s = S_WB;
                    end
                end else if (wait_expired_s) begin
                    next_state_s = S_ERR;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = (instr_opcode == OP_LD);
                reg_dst_s    = (instr_opcode == OP_ADD) || (instr_opcode == OP_SUB) ||
                               (instr_opcode == OP_AND) || (instr_opcode == OP_OR);
                retire_s     = 1'b1;
                next_state_s = retire_next_s;
            end
            S_HALT: begin
                if (resume) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_HALT;
                end
            end
            S_ERR:   next_state_s = S_ERR;
            default: next_state_s = S_ERR;
        endcase

        // The wait counter advances only while a memory phase keeps stalling.
        waiting_s = ((state_r == S_FETCH) || (state_r == S_MEM)) &&
                    !mem_bus.mem_ready && (next_state_s == state_r);
    end

    // State, stall counter, retired-instruction counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_FETCH;
            wait_cnt_r      <= {TO_W{1'b0}};
            instr_retired_r <= {CNT_W{1'b0}};
            bus_err_r       <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= waiting_s ? (wait_cnt_r + TO_W'(1)) : {TO_W{1'b0}};
            if (retire_s) begin
                instr_retired_r <= instr_retired_r + CNT_W'(1);
            end
            if (next_state_s == S_ERR) begin
                bus_err_r <= 1'b1;
            end
        end
    end

    // Strobes drop in the same cycle rst rises, abandoning any access in flight.
    assign ir_load              = ir_load_s      & ~rst;
    assign pc_write             = pc_write_s     & ~rst;
    assign pc_src               = pc_src_s       & {2{~rst}};
    assign link_write           = link_write_s   & ~rst;
    assign mem_bus.mem_req      = mem_req_s      & ~rst;
    assign mem_bus.mem_we       = mem_we_s       & ~rst;
    assign mem_bus.mem_addr_sel = mem_addr_sel_s & ~rst;
    assign alu_src              = alu_src_s      & ~rst;
    assign alu_op               = alu_op_s       & {2{~rst}};
    assign reg_dst              = reg_dst_s      & ~rst;
    assign mem_to_reg           = mem_to_reg_s   & ~rst;
    assign reg_write            = reg_write_s    & ~rst;
    assign flags_write          = flags_write_s  & ~rst;

    assign state         = state_r;
    assign halted        = (state_r == S_HALT);
    assign bus_err       = bus_err_r;
    assign instr_retired = instr_retired_r;

endmodule
